// File: rtl/serial_reverse_rx.sv
// -----------------------------------------------------------------------------
// serial_reverse_rx
//
// Takes a serial bitstream, one bit per cycle, and builds WIDTH-bit frames.
// Each finished frame goes out as a parallel word, in one of two orders:
// received order (first bit = LSB) or reversed (first bit = MSB). One
// completed word is held while the consumer applies backpressure. Input
// stalls only on the final bit of a frame while that held word is still
// waiting.
//
// Optional feature (macro PARITY_CHECK_EN):
//   When defined, each frame carries one trailing even-parity bit. That bit
//   is accepted in S_PAR, and parity_err reports a failure.
//   When undefined, frames are WIDTH bits and parity_err stays 0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bit_in     serial data bit
//   bit_valid  bit_in valid this cycle
//   bit_ready  block accepts a bit (transfer = bit_valid && bit_ready)
//   sof        start of frame, qualified by the bit transfer
//   rev_en     output ordering select, sampled on bit 0 of each frame
//   out_vector assembled word (held)
//   out_valid  out_vector holds a complete frame
//   out_ready  consumer accepts the word
//   parity_err even-parity failure for the held word
//   drop_cnt   saturating count of frames aborted by sof
// -----------------------------------------------------------------------------
module serial_reverse_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             sof,
  input  logic             rev_en,
  output logic [WIDTH-1:0] out_vector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic [7:0]       drop_cnt
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR} state_t;
`else
  typedef enum logic {S_IDLE, S_DATA} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] shift_q;
  logic             rev_q;
`ifdef PARITY_CHECK_EN
  logic             par_q;
`endif

  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] shift_rev;
  logic [WIDTH-1:0] word_next;

  // The bit that would complete the frame is pending.
  always_comb begin
`ifdef PARITY_CHECK_EN
    last_bit = (state == S_PAR);
`else
    last_bit = (state == S_DATA) && (count == LAST_IDX);
`endif
  end

  // Stall only when completing a frame would overwrite a word that is
  // still waiting for the consumer.
  assign bit_ready = !(last_bit && out_valid && !out_ready);
  assign accept    = bit_valid && bit_ready;

  // Shift image with the incoming data bit placed at its position. This
  // image is also the completed word when the last data bit ends the frame.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_map
      assign shift_next[gi] = ((state == S_DATA) && (count == CNT_W'(gi))) ?
                              bit_in : shift_q[gi];
      assign shift_rev[WIDTH-1-gi] = shift_next[gi];
    end
  endgenerate

  assign word_next = rev_q ? shift_rev : shift_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      count      <= '0;
      shift_q    <= '0;
      rev_q      <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
      out_vector <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      // A frame that completes in this same cycle reloads the register and
      // re-sets out_valid below.
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (accept) begin
        if ((state == S_IDLE) || sof) begin
          // Start a new frame. A sof in mid-frame discards the partial frame.
          if ((state != S_IDLE) && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
          rev_q   <= rev_en;
          shift_q <= {{(WIDTH-1){1'b0}}, bit_in};
          count   <= CNT_W'(1);
          state   <= S_DATA;
`ifdef PARITY_CHECK_EN
          par_q   <= bit_in;
`endif
        end else if (state == S_DATA) begin
          shift_q <= shift_next;
`ifdef PARITY_CHECK_EN
          par_q   <= par_q ^ bit_in;
`endif
          if (count == LAST_IDX) begin
`ifdef PARITY_CHECK_EN
            state      <= S_PAR;
`else
            state      <= S_IDLE;
            count      <= '0;
            out_vector <= word_next;
            out_valid  <= 1'b1;
            parity_err <= 1'b0;
`endif
          end else begin
            count <= count + CNT_W'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        else begin
          // Trailing parity bit: even parity over data and parity bit.
          state      <= S_IDLE;
          count      <= '0;
          out_vector <= word_next;
          out_valid  <= 1'b1;
          parity_err <= par_q ^ bit_in;
        end
`endif
      end
    end
  end

endmodule
